// File: rtl/coord_tx_sequencer_pkg.sv
// Shared types and constants for the coordinate TX sequencer.
// Optional checksum byte: define COORD_CHKSUM_EN to build the 6-byte packet
// (trailing XOR byte); leave it undefined for the 5-byte packet.
package coord_tx_pkg;

    // Byte FSM states; CHK is only reachable when the checksum build is enabled.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        XH   = 3'd2,
        XL   = 3'd3,
        YH   = 3'd4,
        YL   = 3'd5,
        CHK  = 3'd6
    } state_t;

    // Sync byte; the sink realigns on this after any aborted packet.
    localparam logic [7:0] PKT_HDR = 8'hAA;

`ifdef COORD_CHKSUM_EN
    localparam int PKT_LEN = 6;
`else
    localparam int PKT_LEN = 5;
`endif

    // XOR of the four coordinate bytes carried in the packet.
    function automatic logic [7:0] coord_chk(input logic [15:0] x, input logic [15:0] y);
        return x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0];
    endfunction

endpackage

// File: rtl/coord_tx_sequencer_if.sv
// Byte-wide TX stream between the sequencer and the UART/host transmitter.
// Handshake: the master raises tx_valid with tx_data and holds both stable
// until the cycle where tx_valid && tx_ready; that cycle transfers the byte.
// tx_valid never depends on tx_ready.
interface coord_tx_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/coord_tx_sequencer_tick_gen.sv
// Free-running divider: counts 0..TICK_DIV-1 and flags the terminal count
// for exactly one cycle per period.
module tick_gen #(
    parameter int TICK_DIV = 27_000_000 / 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Wrap the counter at the terminal count, otherwise increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST_CNT);

endmodule

// File: rtl/coord_tx_sequencer.sv
// Coordinate TX sequencer: frames snapshotted (x, y) coordinates into
// header/coordinate(/checksum) byte packets on a valid/ready byte stream.
// Sends are triggered by coord_vld or the periodic tick; one trigger can be
// queued while a packet is in flight, further ones are dropped and counted.
// Build option: COORD_CHKSUM_EN appends an XOR checksum byte (CHK state).
module coord_tx_sequencer
    import coord_tx_pkg::*;
#(
    parameter int TICK_DIV = 27_000_000 / 10,
    parameter int TICK_EN  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [15:0]                 coord_x,
    input  logic [15:0]                 coord_y,
    input  logic                        coord_vld,
    coord_tx_sequencer_if.master        tx,
    output logic                        busy,
    output logic [7:0]                  drop_cnt,
    output state_t                      dbg_state
);

    // The state whose handshake completes a packet.
    localparam state_t LAST_ST = (PKT_LEN == 6) ? CHK : YL;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic        r_pending;
    logic [7:0]  r_drop_cnt;

    logic        w_tick;
    logic        w_trig;
    logic        w_busy;
    logic        w_hs;
    logic        w_last_hs;
    logic        w_load;

    generate
        if (TICK_EN != 0) begin : g_tick
            tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
                .clk    (clk),
                .rst_n  (rst_n),
                .o_tick (w_tick)
            );
        end else begin : g_no_tick
            assign w_tick = 1'b0;
        end
    endgenerate

    // A tick and a coord_vld in the same cycle merge into one trigger.
    assign w_trig    = coord_vld | w_tick;
    assign w_busy    = (r_state != IDLE);
    assign w_hs      = tx.tx_valid & tx.tx_ready;
    assign w_last_hs = (r_state == LAST_ST) & w_hs;
    // A trigger arriving on the final handshake is served like a queued one,
    // so the next packet follows back-to-back rather than being lost.
    assign w_load    = (!w_busy & w_trig) | (w_last_hs & (r_pending | w_trig));

    // State register; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stream outputs; bytes advance only on a handshake.
    always_comb begin
        w_state_nxt = r_state;
        tx.tx_valid = w_busy;
        tx.tx_data  = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_trig) w_state_nxt = HDR;
            end
            HDR: begin
                tx.tx_data = PKT_HDR;
                if (w_hs) w_state_nxt = XH;
            end
            XH: begin
                tx.tx_data = r_x[15:8];
                if (w_hs) w_state_nxt = XL;
            end
            XL: begin
                tx.tx_data = r_x[7:0];
                if (w_hs) w_state_nxt = YH;
            end
            YH: begin
                tx.tx_data = r_y[15:8];
                if (w_hs) w_state_nxt = YL;
            end
            YL: begin
                tx.tx_data = r_y[7:0];
`ifdef COORD_CHKSUM_EN
                if (w_hs) w_state_nxt = CHK;
`else
                if (w_hs) w_state_nxt = w_load ? HDR : IDLE;
`endif
            end
`ifdef COORD_CHKSUM_EN
            CHK: begin
                tx.tx_data = coord_chk(r_x, r_y);
                if (w_hs) w_state_nxt = w_load ? HDR : IDLE;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Snapshot the coordinates whenever a packet is about to start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_load) begin
            r_x <= coord_x;
            r_y <= coord_y;
        end
    end

    // One-deep trigger queue and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_busy && w_trig && r_pending && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_last_hs) begin
                r_pending <= 1'b0;
            end else if (w_busy && w_trig) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign busy      = w_busy;
    assign drop_cnt  = r_drop_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_coord_tx_sequencer.sv
// Bench for coord_tx_sequencer: directed vector table, hand sequences for the
// multi-cycle corners, and random stimulus against a packet-level model.
// Two DUTs share all inputs: dut_a without the periodic tick, dut_b with it.
`timescale 1ns/1ps
module tb_coord_tx_sequencer;
    import coord_tx_pkg::*;

    localparam int DIV = 16;
`ifdef COORD_CHKSUM_EN
    localparam int LEN = 6;
`else
    localparam int LEN = 5;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] cx = '0;
    logic [15:0] cy = '0;
    logic        cv = 1'b0;
    logic        rdy = 1'b0;

    coord_tx_sequencer_if bus_a();
    coord_tx_sequencer_if bus_b();
    assign bus_a.tx_ready = rdy;
    assign bus_b.tx_ready = rdy;

    logic       busy_a, busy_b;
    logic [7:0] drop_a, drop_b;
    state_t     st_a, st_b;

    coord_tx_sequencer #(.TICK_DIV(DIV), .TICK_EN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .coord_x(cx), .coord_y(cy), .coord_vld(cv),
        .tx(bus_a), .busy(busy_a), .drop_cnt(drop_a), .dbg_state(st_a)
    );

    coord_tx_sequencer #(.TICK_DIV(DIV), .TICK_EN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .coord_x(cx), .coord_y(cy), .coord_vld(cv),
        .tx(bus_b), .busy(busy_b), .drop_cnt(drop_b), .dbg_state(st_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    // Per DUT: the list of packet bytes, how many have been accepted, whether a
    // packet is outstanding, the queued-trigger flag and the drop count.
    logic [7:0] m_pkt [2][6];
    int         m_idx [2];
    bit         m_busy[2];
    bit         m_pend[2];
    int         m_drop[2];
    int         m_k;

    task automatic model_reset();
        m_k = 0;
        for (int d = 0; d < 2; d++) begin
            m_idx[d] = 0; m_busy[d] = 0; m_pend[d] = 0; m_drop[d] = 0;
        end
    endtask

    task automatic model_load(input int d, input logic [15:0] x, input logic [15:0] y);
        m_pkt[d][0] = 8'hAA;
        m_pkt[d][1] = x[15:8];
        m_pkt[d][2] = x[7:0];
        m_pkt[d][3] = y[15:8];
        m_pkt[d][4] = y[7:0];
        m_pkt[d][5] = x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0];
        m_idx[d] = 0;
        m_busy[d] = 1;
    endtask

    task automatic model_step(input logic [15:0] x, input logic [15:0] y, input bit v, input bit r);
        bit tick, trig, hs, fin;
        tick = ((m_k % DIV) == DIV - 1);
        m_k++;
        for (int d = 0; d < 2; d++) begin
            trig = v | ((d == 1) & tick);
            if (!m_busy[d]) begin
                if (trig) model_load(d, x, y);
            end else begin
                hs  = r;
                fin = hs && (m_idx[d] == LEN - 1);
                if (trig && m_pend[d] && m_drop[d] < 255) m_drop[d]++;
                if (fin) begin
                    if (m_pend[d] || trig) model_load(d, x, y);
                    else m_busy[d] = 0;
                    m_pend[d] = 0;
                end else begin
                    if (trig) m_pend[d] = 1;
                    if (hs) m_idx[d]++;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic cmp_all();
        logic [7:0] ea, eb;
        ea = m_busy[0] ? m_pkt[0][m_idx[0]] : 8'h00;
        eb = m_busy[1] ? m_pkt[1][m_idx[1]] : 8'h00;
        check("a_valid", 32'(bus_a.tx_valid), 32'(m_busy[0]));
        check("a_busy",  32'(busy_a),         32'(m_busy[0]));
        if (m_busy[0]) check("a_data", 32'(bus_a.tx_data), 32'(ea));
        check("a_drop",  32'(drop_a),         32'(m_drop[0]));
        check("b_valid", 32'(bus_b.tx_valid), 32'(m_busy[1]));
        check("b_busy",  32'(busy_b),         32'(m_busy[1]));
        if (m_busy[1]) check("b_data", 32'(bus_b.tx_data), 32'(eb));
        check("b_drop",  32'(drop_b),         32'(m_drop[1]));
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic [15:0] x, input logic [15:0] y, input bit v, input bit r);
        cx = x; cy = y; cv = v; rdy = r;
        @(posedge clk);
        model_step(x, y, v, r);
        #1;
        cmp_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cv = 1'b0; rdy = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 32'(bus_a.tx_valid), 0);
        check("rst_busy",  32'(busy_a), 0);
        check("rst_drop",  32'(drop_a), 0);
        check("rst_state", 32'(st_a), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_valid", 32'(bus_a.tx_valid), 0);
        check("rst_hold_data",  32'(bus_a.tx_data), 0);
        check("rst_b_valid",    32'(bus_b.tx_valid), 0);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        bit          v;
        bit          r;
        bit          e_valid;
        logic [7:0]  e_data;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] x, input logic [15:0] y, input bit v, input bit r,
                       input bit ev, input logic [7:0] ed);
        vec_t t;
        t.x = x; t.y = y; t.v = v; t.r = r; t.e_valid = ev; t.e_data = ed; t.e_drop = 8'd0;
        vecs.push_back(t);
    endtask

    logic [7:0] exp3[$];
    logic [7:0] got;
    int cnt, starts, last_start;
    bit prev;

    initial begin
        do_reset();

        // Single packet x=150 y=300, then a stalled packet with inputs changed mid-way.
        add(150, 300, 1, 1, 1, 8'hAA);
        add(150, 300, 0, 1, 1, 8'h00);
        add(150, 300, 0, 1, 1, 8'h96);
        add(150, 300, 0, 1, 1, 8'h01);
        add(150, 300, 0, 1, 1, 8'h2C);
`ifdef COORD_CHKSUM_EN
        add(150, 300, 0, 1, 1, 8'hBB);
`endif
        add(150, 300, 0, 1, 0, 8'h00);
        add(150, 300, 1, 1, 1, 8'hAA);
        add(150, 300, 0, 1, 1, 8'h00);
        add(150, 300, 0, 1, 1, 8'h96);
        for (int i = 0; i < 5; i++) add(400, 300, 0, 0, 1, 8'h96);
        add(400, 300, 0, 1, 1, 8'h01);
        add(400, 300, 0, 1, 1, 8'h2C);
`ifdef COORD_CHKSUM_EN
        add(400, 300, 0, 1, 1, 8'hBB);
`endif
        add(400, 300, 0, 1, 0, 8'h00);

        foreach (vecs[i]) begin
            cycle(vecs[i].x, vecs[i].y, vecs[i].v, vecs[i].r);
            check($sformatf("vec%0d_valid", i), 32'(bus_a.tx_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_busy", i),  32'(busy_a),         32'(vecs[i].e_valid));
            check($sformatf("vec%0d_data", i),  32'(bus_a.tx_data),  32'(vecs[i].e_data));
            check($sformatf("vec%0d_drop", i),  32'(drop_a),         32'(vecs[i].e_drop));
        end

        // Back-to-back: second trigger during HDR, new coordinates held after it.
        exp3 = '{8'hAA, 8'h00, 8'h96, 8'h01, 8'h2C};
`ifdef COORD_CHKSUM_EN
        exp3.push_back(8'hBB);
`endif
        exp3.push_back(8'hAA); exp3.push_back(8'h01); exp3.push_back(8'hF4);
        exp3.push_back(8'h02); exp3.push_back(8'h58);
`ifdef COORD_CHKSUM_EN
        exp3.push_back(8'hAF);
`endif
        cycle(150, 300, 1, 1);
        check("b2b_valid0", 32'(bus_a.tx_valid), 1);
        check("b2b_byte0", 32'(bus_a.tx_data), 32'(exp3[0]));
        cycle(500, 600, 1, 1);
        for (int i = 1; i < 2 * LEN; i++) begin
            if (i > 1) cycle(500, 600, 0, 1);
            got = bus_a.tx_data;
            check($sformatf("b2b_valid%0d", i), 32'(bus_a.tx_valid), 1);
            check($sformatf("b2b_byte%0d", i), 32'(got), 32'(exp3[i]));
        end
        cycle(500, 600, 0, 1);
        check("b2b_end_valid", 32'(bus_a.tx_valid), 0);
        check("b2b_drop", 32'(drop_a), 0);

        // Overflow: three triggers while stalled -> one queued, two dropped.
        cycle(1, 2, 1, 0);
        for (int i = 0; i < 3; i++) cycle(3, 4, 1, 0);
        check("ovf_drop2", 32'(drop_a), 2);
        cnt = 0;
        for (int i = 0; i < 2 * LEN; i++) begin
            cycle(3, 4, 0, 1);
            if (bus_a.tx_valid) cnt++;
        end
        check("ovf_valid_cycles", 32'(cnt), 32'(2 * LEN - 1));
        check("ovf_idle", 32'(busy_a), 0);
        cycle(5, 6, 1, 0);
        for (int i = 0; i < 301; i++) cycle(5, 6, 1, 0);
        check("ovf_sat", 32'(drop_a), 255);
        for (int i = 0; i < 2 * LEN + 2; i++) cycle(5, 6, 0, 1);
        check("ovf_drain", 32'(busy_a), 0);
        check("ovf_sat_hold", 32'(drop_a), 255);

        // Reset during YH aborts the packet; the next one starts with the header.
        cycle(16'h1234, 16'h5678, 1, 1);
        for (int i = 0; i < 3; i++) cycle(16'h1234, 16'h5678, 0, 1);
        check("yh_state", 32'(st_a), 32'(YH));
        check("yh_data", 32'(bus_a.tx_data), 32'h56);
        do_reset();
        cycle(16'h0007, 16'h0008, 1, 1);
        check("post_rst_hdr", 32'(bus_a.tx_data), 32'hAA);
        cycle(16'h0007, 16'h0008, 0, 1);
        check("post_rst_xh", 32'(bus_a.tx_data), 32'h00);
        cycle(16'h0007, 16'h0008, 0, 1);
        check("post_rst_xl", 32'(bus_a.tx_data), 32'h07);
        for (int i = 0; i < LEN; i++) cycle(0, 0, 0, 1);
        check("post_rst_idle", 32'(busy_a), 0);

        // Periodic tick on dut_b: one start per DIV cycles from reset.
        do_reset();
        starts = 0; last_start = -1; prev = 0;
        for (int i = 0; i < 4 * DIV; i++) begin
            cycle(16'h0102, 16'h0304, 0, 1);
            if (bus_b.tx_valid && !prev) begin
                if (last_start >= 0) check("tick_period", 32'(i - last_start), 32'(DIV));
                else check("tick_first", 32'(i), 32'(DIV - 1));
                last_start = i;
                starts++;
            end
            prev = bus_b.tx_valid;
        end
        check("tick_starts", 32'(starts), 4);
        check("tick_a_idle", 32'(busy_a), 0);
        for (int i = 0; i < DIV - 1; i++) cycle(0, 0, 0, 1);
        cycle(16'h0A0B, 16'h0C0D, 1, 1);
        cnt = bus_b.tx_valid ? 1 : 0;
        for (int i = 0; i < DIV - 1; i++) begin
            cycle(0, 0, 0, 1);
            if (bus_b.tx_valid) cnt++;
        end
        check("tick_coinc_len", 32'(cnt), 32'(LEN));
        check("tick_coinc_drop", 32'(drop_b), 0);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
